// File: rtl/sm3_adder_pipe.sv
// sm3_adder_pipe: two-stage masked multi-operand adder mod 2^WIDTH with valid/ready and tag sideband.
// Define SM3_ADDER_ROTL_EN to add the in_rot port and a left rotate on the registered sum.
module sm3_adder_pipe #(
    parameter int WIDTH   = 32,
    parameter int NUM_OPS = 4,
    parameter int TAG_W   = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NUM_OPS*WIDTH-1:0]   in_ops,
    input  logic [NUM_OPS-1:0]         in_mask,
    input  logic [TAG_W-1:0]           in_tag,
`ifdef SM3_ADDER_ROTL_EN
    input  logic [5:0]                 in_rot,
`endif
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_sum,
    output logic [TAG_W-1:0]           out_tag
);
    logic               en1, en2;
    logic               s1_valid, s2_valid;
    logic [WIDTH-1:0]   s1_s, s1_c, s2_sum;
    logic [TAG_W-1:0]   s1_tag, s2_tag;
    logic [WIDTH-1:0]   cs_s, cs_c, op, t, cpa, s2_d;

    assign en2       = !s2_valid || out_ready;
    assign en1       = !s1_valid || en2;
    assign in_ready  = en1;
    assign out_valid = s2_valid;
    assign out_sum   = s2_sum;
    assign out_tag   = s2_tag;

    // 3:2 compressors fold each masked slot into the running sum/carry pair; top carries drop out
    always_comb begin
        cs_s = '0;
        cs_c = '0;
        op   = '0;
        t    = '0;
        for (int i = 0; i < NUM_OPS; i++) begin
            op   = in_mask[i] ? in_ops[i*WIDTH +: WIDTH] : '0;
            t    = cs_s ^ cs_c ^ op;
            cs_c = ((cs_s & cs_c) | (cs_s & op) | (cs_c & op)) << 1;
            cs_s = t;
        end
    end

    assign cpa = s1_s + s1_c;

`ifdef SM3_ADDER_ROTL_EN
    logic [5:0] s1_rot;
    logic [6:0] ramt;
    assign ramt = {1'b0, s1_rot} % 7'(WIDTH);
    assign s2_d = (cpa << ramt) | (cpa >> (7'(WIDTH) - ramt));
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            s1_rot <= '0;
        else if (en1 && in_valid)
            s1_rot <= in_rot;
`else
    assign s2_d = cpa;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_s     <= '0;
            s1_c     <= '0;
            s1_tag   <= '0;
            s2_valid <= 1'b0;
            s2_sum   <= '0;
            s2_tag   <= '0;
        end else begin
            if (en1)
                s1_valid <= in_valid;
            if (en1 && in_valid) begin
                s1_s   <= cs_s;
                s1_c   <= cs_c;
                s1_tag <= in_tag;
            end
            if (en2)
                s2_valid <= s1_valid;
            if (en2 && s1_valid) begin
                s2_sum <= s2_d;
                s2_tag <= s1_tag;
            end
        end
    end
endmodule

// File: tb/tb_sm3_adder_pipe.sv
// tb_sm3_adder_pipe: random and directed stimulus for sm3_adder_pipe against an arithmetic reference queue.
module tb_sm3_adder_pipe;
    localparam int W = 32;
    localparam int N = 4;
    localparam int T = 4;

    typedef struct {
        logic [W-1:0] sum;
        logic [T-1:0] tag;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [N*W-1:0] in_ops = '0;
    logic [N-1:0]   in_mask = '0;
    logic [T-1:0]   in_tag = '0;
    logic [5:0]     in_rot = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [W-1:0]   out_sum;
    logic [T-1:0]   out_tag;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   n_acc = 0;
    int   n_out = 0;
    bit   last_acc;

    sm3_adder_pipe #(.WIDTH(W), .NUM_OPS(N), .TAG_W(T)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_ops(in_ops),
        .in_mask(in_mask),
        .in_tag(in_tag),
`ifdef SM3_ADDER_ROTL_EN
        .in_rot(in_rot),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum(out_sum),
        .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_sum(input logic [N*W-1:0] ops, input logic [N-1:0] m,
                                             input logic [5:0] rot);
        longint unsigned acc = 0;
        logic [W-1:0] s;
        int r;
        for (int i = 0; i < N; i++)
            if (m[i]) acc += longint'(ops[i*W +: W]);
        s = W'(acc % (64'd1 << W));
`ifdef SM3_ADDER_ROTL_EN
        r = int'(rot) % W;
        if (r != 0) s = (s << r) | (s >> (W - r));
`else
        r = int'(rot);
        if (r < 0) s = '0;
`endif
        return s;
    endfunction

    // one clock: observe settled outputs, update the model, advance to the next falling edge
    task automatic tick();
        #1;
        last_acc = 1'b0;
        if (out_valid) begin
            if (exp_q.size() == 0)
                chk("spurious_valid", {63'd0, out_valid}, 64'd0);
            else begin
                chk("sum", 64'(out_sum), 64'(exp_q[0].sum));
                chk("tag", 64'(out_tag), 64'(exp_q[0].tag));
            end
        end
        if (out_valid && out_ready && exp_q.size() > 0) begin
            void'(exp_q.pop_front());
            n_out++;
        end
        if (in_valid && in_ready) begin
            exp_q.push_back('{ref_sum(in_ops, in_mask, in_rot), in_tag});
            n_acc++;
            last_acc = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        int c = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (exp_q.size() > 0 && c < 20) begin
            tick();
            c++;
        end
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic send_one(input string tag, input logic [N*W-1:0] ops, input logic [N-1:0] m,
                            input logic [T-1:0] tg, input logic [5:0] rot, input logic [W-1:0] want);
        int lat = 1;
        in_ops    = ops;
        in_mask   = m;
        in_tag    = tg;
        in_rot    = rot;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        chk({tag, "_accept"}, {63'd0, last_acc}, 64'd1);
        in_valid = 1'b0;
        while (!out_valid && lat < 10) begin
            tick();
            lat++;
        end
        chk({tag, "_latency"}, 64'(lat), 64'd2);
        chk({tag, "_sum"}, 64'(out_sum), 64'(want));
        chk({tag, "_tag"}, 64'(out_tag), 64'(tg));
        tick();
    endtask

    initial begin
        int tg;
        int c;
        #3;
        chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
        chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset_out_sum", 64'(out_sum), 64'd0);
        chk("reset_out_tag", 64'(out_tag), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        send_one("tp1", {32'hDEADBEEF, 32'h172442D7, 32'h4914B2B9, 32'h7380166F}, 4'b0111,
                 4'h5, 6'd0, 32'hD3B90BFF);
        send_one("wrap_all", {4{32'hFFFFFFFF}}, 4'hF, 4'h9, 6'd0, 32'hFFFFFFFC);
        send_one("wrap_none", {4{32'hFFFFFFFF}}, 4'h0, 4'hA, 6'd0, 32'h00000000);
`ifdef SM3_ADDER_ROTL_EN
        send_one("rot1", {32'd0, 32'd0, 32'h00000001, 32'h80000000}, 4'h3, 4'h3, 6'd1, 32'h00000003);
        send_one("rot32", {32'd0, 32'd0, 32'h00000001, 32'h80000000}, 4'h3, 4'h4, 6'd32, 32'h80000001);
`endif

        // backpressure: only two sets fit while the consumer stalls
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_rot    = '0;
        tg = 1;
        c  = 0;
        repeat (4) begin
            in_tag  = T'(tg);
            in_ops  = {$urandom, $urandom, $urandom, $urandom};
            in_mask = N'($urandom);
            tick();
            if (last_acc) begin
                tg++;
                c++;
            end
        end
        chk("bp_accepts", 64'(c), 64'd2);
        #1;
        chk("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
        out_ready = 1'b1;
        #1;
        chk("bp_in_ready_comb", {63'd0, in_ready}, 64'd1);
        while (tg <= 3 && c < 10) begin
            in_tag = T'(tg);
            tick();
            if (last_acc) tg++;
            c++;
        end
        drain();

        // full-rate stream
        c = n_out;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            in_ops  = {$urandom, $urandom, $urandom, $urandom};
            in_mask = N'($urandom);
            in_tag  = T'(i);
            in_rot  = 6'($urandom);
            tick();
            chk("stream_accept", {63'd0, last_acc}, 64'd1);
        end
        in_valid = 1'b0;
        tick();
        tick();
        chk("stream_outputs", 64'(n_out - c), 64'd64);
        chk("stream_empty", 64'(exp_q.size()), 64'd0);

        // random valid and ready
        c = n_acc;
        for (int i = 0; i < 200; i++) begin
            if (!in_valid || last_acc) begin
                in_ops  = (i % 7 == 0) ? {4{32'hFFFFFFFF}} : {$urandom, $urandom, $urandom, $urandom};
                in_mask = N'($urandom);
                in_tag  = T'($urandom);
                in_rot  = 6'($urandom);
            end
            in_valid  = 1'($urandom_range(0, 3) != 0);
            out_ready = 1'($urandom_range(0, 2) != 0);
            tick();
        end
        drain();
        chk("random_some_accepted", 64'(n_acc - c > 50), 64'd1);

        // asynchronous reset with two entries held
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ops    = {$urandom, $urandom, $urandom, $urandom};
        in_mask   = 4'hF;
        tick();
        tick();
        in_valid = 1'b0;
        #1;
        chk("held_full", {62'd0, out_valid, in_ready}, 64'd2);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("arst_out_sum", 64'(out_sum), 64'd0);
        chk("arst_out_tag", 64'(out_tag), 64'd0);
        chk("arst_in_ready", {63'd0, in_ready}, 64'd1);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", {63'd0, out_valid}, 64'd0);
        send_one("post_rst", {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444}, 4'hF,
                 4'h7, 6'd0, 32'hAAAAAAAA);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/sm3_adder_pipe.md
# sm3_adder_pipe

Parametrised, pipelined multi-operand modular adder for the SM3 compression datapath. Sums up to `NUM_OPS` `WIDTH`-bit operands modulo 2^WIDTH through a carry-save reduction tree and a registered final carry-propagate add. It uses a valid/ready handshake with full backpressure and carries a sideband tag. It replaces fixed 3-input combinational adders in round logic where TT1/TT2/SS1-style sums need more operands, per-operand masking, or a registered boundary.

## Interface
Parameters:
- `WIDTH`, 32, operand and result width; legal range 8..64.
- `NUM_OPS`, 4, number of operand slots; legal range 2..8.
- `TAG_W`, 4, width of the sideband tag carried alongside each sum; legal range 1..16.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  operand set presented.
- `in_ready`  out  1  block can accept an operand set this cycle.
- `in_ops`  in  NUM_OPS*WIDTH  packed operands; slot i occupies bits [i*WIDTH +: WIDTH].
- `in_mask`  in  NUM_OPS  bit i=1 includes slot i; bit i=0 treats slot i as zero.
- `in_tag`  in  TAG_W  opaque sideband, returned unchanged with the result.
- `in_rot`  in  6  left-rotate amount. Present only with `SM3_ADDER_ROTL_EN`.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts the result.
- `out_sum`  out  WIDTH  masked sum mod 2^WIDTH (rotated if enabled).
- `out_tag`  out  TAG_W  tag of the result.

## Operation
- Input transfer occurs when `in_valid && in_ready`. Output transfer occurs when `out_valid && out_ready`.
- Stage 1 registers:
  - masked operands reduced to a sum/carry pair by a 3:2 CSA tree;
  - tag;
  - rotate amount (with macro);
  - `s1_valid`.
- Stage 2 registers:
  - final CPA sum of the pair, rotated if enabled;
  - tag;
  - `s2_valid`.
- Stage 2 registers drive `out_sum`, `out_tag` and `out_valid` directly.
- Arithmetic: result = Σ(in_mask[i] ? op_i : 0) mod 2^WIDTH. All carries out of bit WIDTH-1 are discarded at every CSA level and in the CPA.
- Load enables:
  - `en2 = !s2_valid || out_ready`
  - `en1 = !s1_valid || en2`
  - `in_ready = en1` (combinational from state and `out_ready`; no path from `in_valid`).
- Stage 1 valid: when `en1`, `s1_valid <= in_valid`; data registers load only on input transfer.
- Stage 2 valid: when `en2`, `s2_valid <= s1_valid`; data registers load only when `s1_valid`.
- Bubble collapse: an empty stage fills even if the downstream stage is stalled.
- Holding: under `out_ready=0`, `out_sum` and `out_tag` hold stable while `out_valid=1`.
- Ordering: strictly in order, no drops, no duplicates.
- Reset:
  - `out_valid=0`, `out_sum=0`, `out_tag=0`, all internal valid and data registers 0.
  - `in_ready` reads 1 while `rst_n` is low and after release.
  - Reset mid-operation discards both in-flight entries immediately, with no partial output.
  - No transfer is recognised while `rst_n` is low.

## Timing
- Latency: 2 cycles. A set accepted at edge k appears with `out_valid=1` after edge k+1 and is consumable at edge k+2 when `out_ready` is held high.
- Throughput: 1 set per cycle with `out_ready` held high.
- Capacity: 2 entries. With `out_ready=0`, exactly two sets are accepted, then `in_ready` drops.
- Simultaneous events: when full, an output transfer and an input transfer in the same cycle are allowed; occupancy is unchanged.
- After a stall releases, `in_ready` rises in the same cycle `out_ready` rises, combinationally.

## Configuration
- `SM3_ADDER_ROTL_EN` defined:
  - port `in_rot` exists and is pipelined with the data;
  - stage 2 stores `sum <<< (in_rot mod WIDTH)`;
  - rotate amount 0 gives the plain sum.
  - This covers SM3's `(x) <<< 7` and `T_j <<< j` needs without an extra stage.
- Undefined: `in_rot` is absent, no rotator logic is present, and `out_sum` is the plain masked sum. Latency is 2 in both builds.

## Test plan
- Defaults, mask 4'b0111, ops {0x7380166F, 0x4914B2B9, 0x172442D7, 0xDEADBEEF}, tag 0x5 -> `out_sum=0xD3B90BFF`, `out_tag=0x5`, exactly 2 cycles after acceptance.
- Wrap-around: all four ops 0xFFFFFFFF, mask 4'hF -> `out_sum=0xFFFFFFFC`; mask 4'h0 -> `out_sum=0x00000000`.
- Backpressure: `out_ready=0`, stream tags 1,2,3 -> `in_ready` falls after 2 accepts. Raise `out_ready` -> tags emerge 1,2,3 in order, with data stable throughout the stall.
- Full-rate stream: 64 random sets with `out_ready=1` -> one result per cycle, matching the reference model sum. Then random `out_ready` -> same results with no loss.
- Reset mid-flight: assert `rst_n=0` asynchronously with 2 entries held -> `out_valid=0` and `out_sum=0` immediately. After release, the first new set returns 2 cycles after acceptance.
- With `SM3_ADDER_ROTL_EN`: ops {0x80000000, 0x00000001, 0, 0}, mask 4'h3, `in_rot=1` -> `out_sum=0x00000003`; `in_rot=32` -> `out_sum=0x80000001`.
